// File: rtl/bell_sequencer_if.sv
// Signal bundle between the timekeeping side (time counter, tone dividers, keys)
// and the bell sequencer that owns the buzzer pin.
interface bell_sequencer_if;
  logic        sec_tick;
  logic [23:0] hms;
  logic        toll_en;
  logic        alarm_en;
  logic [15:0] alarm_hm;
  logic        stop_key;
  logic        c500;
  logic        c1k;
  logic        bell;
  logic        busy;
  logic        alarm_active;
  logic [3:0]  strikes_left;

  modport master (
    output sec_tick, hms, toll_en, alarm_en, alarm_hm, stop_key, c500, c1k,
    input  bell, busy, alarm_active, strikes_left
  );

  modport slave (
    input  sec_tick, hms, toll_en, alarm_en, alarm_hm, stop_key, c500, c1k,
    output bell, busy, alarm_active, strikes_left
  );
endinterface

// File: rtl/bell_sequencer.sv
// Hourly strike / minute alarm sequencer driving the single buzzer output.
// The alarm has priority over the strike; the silence key aborts either one.
module bell_sequencer #(
  parameter int ALARM_SECS = 60
) (
  input  logic            CP,
  input  logic            nCR,
  bell_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STRIKE_ON  = 2'd1,
    STRIKE_OFF = 2'd2,
    ALARM      = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  strikes, strikes_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic        gate, gate_nxt;
  logic        tone_sel, tone_sel_nxt;
  logic [3:0]  hour12;
  logic        strike_trig, alarm_trig, in_strike;

  // BCD 24-hour value to 12-hour strike count; 0 means "do not strike".
  function automatic logic [3:0] to_hour12(input logic [7:0] h);
    logic [3:0] tens, ones;
    logic [4:0] bin;
    logic       valid;
    tens  = h[7:4];
    ones  = h[3:0];
    valid = (ones <= 4'd9) && ((tens <= 4'd1) || (tens == 4'd2 && ones <= 4'd3));
    case (tens)
      4'd0:    bin = {1'b0, ones};
      4'd1:    bin = {1'b0, ones} + 5'd10;
      default: bin = {1'b0, ones} + 5'd20;
    endcase
    if (!valid)
      to_hour12 = 4'd0;
    else if (bin == 5'd0)
      to_hour12 = 4'd12;
    else if (bin <= 5'd12)
      to_hour12 = bin[3:0];
    else
      to_hour12 = 4'(bin - 5'd12);
  endfunction

  assign hour12      = to_hour12(bus.hms[23:16]);
  assign strike_trig = bus.sec_tick && bus.toll_en && (bus.hms[15:0] == 16'h0000) &&
                       (hour12 != 4'd0);
  assign alarm_trig  = bus.sec_tick && bus.alarm_en && (bus.hms[23:8] == bus.alarm_hm) &&
                       (bus.hms[7:0] == 8'h00);
  assign in_strike   = (state == STRIKE_ON) || (state == STRIKE_OFF);

  always_comb begin
    state_nxt   = state;
    strikes_nxt = strikes;
    cnt_nxt     = cnt;
    if (state != IDLE && bus.stop_key) begin
      state_nxt   = IDLE;
      strikes_nxt = 4'd0;
      cnt_nxt     = 6'd0;
    end else if ((in_strike && !bus.toll_en) || (state == ALARM && !bus.alarm_en)) begin
      state_nxt   = IDLE;
      strikes_nxt = 4'd0;
      cnt_nxt     = 6'd0;
    end else if (in_strike && alarm_trig) begin
      state_nxt   = ALARM;
      strikes_nxt = 4'd0;
      cnt_nxt     = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          // A silence key coinciding with a trigger keeps us idle.
          if (!bus.stop_key) begin
            if (alarm_trig) begin
              state_nxt = ALARM;
              cnt_nxt   = 6'd0;
            end else if (strike_trig) begin
              state_nxt   = STRIKE_ON;
              strikes_nxt = hour12;
            end
          end
        end
        STRIKE_ON: begin
          if (bus.sec_tick) begin
            state_nxt   = STRIKE_OFF;
            strikes_nxt = strikes - 4'd1;
          end
        end
        STRIKE_OFF: begin
          if (bus.sec_tick)
            state_nxt = (strikes == 4'd0) ? IDLE : STRIKE_ON;
        end
        ALARM: begin
          if (bus.sec_tick) begin
            if (cnt == 6'(ALARM_SECS - 1)) begin
              state_nxt = IDLE;
              cnt_nxt   = 6'd0;
            end else begin
              cnt_nxt = cnt + 6'd1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Gate and tone select are registered from the next state so the only
  // combinational path to the pin is the final AND with the tone.
  always_comb begin
    gate_nxt     = (state_nxt == STRIKE_ON) || (state_nxt == ALARM && !cnt_nxt[0]);
    tone_sel_nxt = (state_nxt == ALARM);
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state    <= IDLE;
      strikes  <= 4'd0;
      cnt      <= 6'd0;
      gate     <= 1'b0;
      tone_sel <= 1'b0;
    end else begin
      state    <= state_nxt;
      strikes  <= strikes_nxt;
      cnt      <= cnt_nxt;
      gate     <= gate_nxt;
      tone_sel <= tone_sel_nxt;
    end
  end

  assign bus.bell         = gate & (tone_sel ? bus.c1k : bus.c500);
  assign bus.busy         = (state != IDLE);
  assign bus.alarm_active = (state == ALARM);
  assign bus.strikes_left = strikes;

endmodule

// File: tb/tb_bell_sequencer.sv
// Directed bench for bell_sequencer: strikes, alarm, priority, aborts, reset.
module tb_bell_sequencer;
  logic CP = 1'b0;
  logic nCR = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  bell_sequencer_if bus ();

  bell_sequencer #(.ALARM_SECS(60)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle second strobe, followed by one quiet cycle; returns at a negedge.
  task automatic tick();
    @(negedge CP) bus.sec_tick = 1'b1;
    @(negedge CP) bus.sec_tick = 1'b0;
  endtask

  task automatic run_until_idle(output int cnt);
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_stop();
    @(negedge CP) bus.stop_key = 1'b1;
    @(negedge CP) bus.stop_key = 1'b0;
  endtask

  initial begin
    bus.sec_tick = 1'b0;
    bus.hms      = 24'h000001;
    bus.toll_en  = 1'b0;
    bus.alarm_en = 1'b0;
    bus.alarm_hm = 16'h0000;
    bus.stop_key = 1'b0;
    bus.c500     = 1'b1;
    bus.c1k      = 1'b1;
    #22;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_bell", 32'(bus.bell), 0);
    chk("rst_alarm", 32'(bus.alarm_active), 0);
    chk("rst_sl", 32'(bus.strikes_left), 0);
    @(negedge CP) nCR = 1'b1;

    // 03:00:00 strike
    bus.toll_en = 1'b1;
    bus.hms = 24'h030000;
    tick();
    chk("s3_sl", 32'(bus.strikes_left), 3);
    chk("s3_busy", 32'(bus.busy), 1);
    chk("s3_bell_on", 32'(bus.bell), 1);
    bus.c500 = 1'b0;
    #1 chk("s3_bell_tone", 32'(bus.bell), 0);
    bus.c500 = 1'b1;
    bus.hms = 24'h030001;
    tick(); chk("s3_k1_sl", 32'(bus.strikes_left), 2); chk("s3_k1_bell", 32'(bus.bell), 0);
    tick(); chk("s3_k2_sl", 32'(bus.strikes_left), 2); chk("s3_k2_bell", 32'(bus.bell), 1);
    tick(); chk("s3_k3_sl", 32'(bus.strikes_left), 1); chk("s3_k3_bell", 32'(bus.bell), 0);
    tick(); chk("s3_k4_sl", 32'(bus.strikes_left), 1); chk("s3_k4_bell", 32'(bus.bell), 1);
    tick(); chk("s3_k5_sl", 32'(bus.strikes_left), 0); chk("s3_k5_busy", 32'(bus.busy), 1);
    tick(); chk("s3_k6_busy", 32'(bus.busy), 0); chk("s3_k6_bell", 32'(bus.bell), 0);

    // 00:00:00 -> 12 strikes, 24 s
    bus.hms = 24'h000000;
    tick();
    chk("s12_sl", 32'(bus.strikes_left), 12);
    bus.hms = 24'h000001;
    run_until_idle(n);
    chk("s12_len", 32'(n), 24);

    // 13:00:00 -> 1 strike
    bus.hms = 24'h130000;
    tick();
    chk("s13_sl", 32'(bus.strikes_left), 1);
    bus.hms = 24'h130001;
    run_until_idle(n);
    chk("s13_len", 32'(n), 2);

    // invalid hour 25
    bus.hms = 24'h250000;
    tick();
    chk("h25_busy", 32'(bus.busy), 0);

    // 07:30 alarm
    bus.toll_en  = 1'b0;
    bus.alarm_en = 1'b1;
    bus.alarm_hm = 16'h0730;
    bus.hms = 24'h073000;
    tick();
    chk("al_active", 32'(bus.alarm_active), 1);
    chk("al_bell0", 32'(bus.bell), 1);
    bus.c1k = 1'b0;
    #1 chk("al_tone_sel", 32'(bus.bell), 0);
    bus.c1k = 1'b1;
    bus.hms = 24'h073001;
    tick(); chk("al_bell1", 32'(bus.bell), 0);
    tick(); chk("al_bell2", 32'(bus.bell), 1);
    run_until_idle(n);
    chk("al_len", 32'(n), 58);
    chk("al_end_active", 32'(bus.alarm_active), 0);

    // 08:00 alarm beats 8 strikes, then silenced
    bus.toll_en  = 1'b1;
    bus.alarm_hm = 16'h0800;
    bus.hms = 24'h080000;
    tick();
    chk("al8_active", 32'(bus.alarm_active), 1);
    chk("al8_sl", 32'(bus.strikes_left), 0);
    bus.hms = 24'h080001;
    tick(); tick();
    pulse_stop();
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_bell", 32'(bus.bell), 0);

    // alarm preempts the second strike of 05:00
    bus.alarm_hm = 16'h0501;
    bus.hms = 24'h050000;
    tick();
    chk("s5_sl", 32'(bus.strikes_left), 5);
    bus.hms = 24'h050001;
    tick(); tick();
    chk("s5_2nd_sl", 32'(bus.strikes_left), 4);
    bus.hms = 24'h050100;
    tick();
    chk("pre_active", 32'(bus.alarm_active), 1);
    chk("pre_sl", 32'(bus.strikes_left), 0);
    bus.hms = 24'h050101;
    pulse_stop();
    chk("pre_stop", 32'(bus.busy), 0);

    // toll_en dropped in STRIKE_OFF
    bus.alarm_en = 1'b0;
    bus.hms = 24'h020000;
    tick();
    bus.hms = 24'h020001;
    tick();
    chk("drop_pre", 32'(bus.busy), 1);
    @(negedge CP) bus.toll_en = 1'b0;
    @(negedge CP) chk("drop_busy", 32'(bus.busy), 0);
    bus.toll_en = 1'b1;

    // stop_key on the trigger edge wins
    bus.hms = 24'h040000;
    @(negedge CP) begin bus.sec_tick = 1'b1; bus.stop_key = 1'b1; end
    @(negedge CP) begin bus.sec_tick = 1'b0; bus.stop_key = 1'b0; end
    chk("stop_trig", 32'(bus.busy), 0);

    // async reset during a strike-on second
    bus.hms = 24'h060000;
    tick();
    bus.hms = 24'h060001;
    tick(); tick();
    chk("ar_pre_bell", 32'(bus.bell), 1);
    #2 nCR = 1'b0;
    #1;
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_bell", 32'(bus.bell), 0);
    chk("ar_sl", 32'(bus.strikes_left), 0);
    @(negedge CP) nCR = 1'b1;
    bus.hms = 24'h010000;
    tick();
    chk("ar_s1_sl", 32'(bus.strikes_left), 1);
    bus.hms = 24'h010001;
    run_until_idle(n);
    chk("ar_s1_len", 32'(n), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
